change_dispenser: RTL

- Downstream of vending_machine. Consumes its change outputs (quart, dim, nick coin counts) and drives the coin-tube eject solenoids one coin at a time.
- Each coin is confirmed by the coin-exit sensor before the next one is ejected.
- Reports progress (busy, remaining cents), completion (done) and mechanical faults (missing sensor acknowledge, empty tube).

---
 rtl/change_dispenser.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays out quarter/dime/nickel change one coin at a time,
// waiting for the coin-exit sensor to confirm each coin before ejecting the next.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   load         one-cycle strobe, captures quart/dim/nick (accepted in IDLE only)
//   quart/dim/nick  coin counts to dispense
//   coin_ack     coin-exit sensor level, high when a coin has passed
//   tube_empty   {quarter, dime, nickel} tube-empty flags, sampled when choosing a coin
//   fault_clr    clears a sticky fault and abandons the undelivered change
//   eject_q/d/n  tube solenoids, at most one high at a time
//   busy         dispensing in progress
//   done         one-cycle pulse when all coins are out
//   fault        sticky fault flag
//   fault_code   0 none, 1 ack timeout, 2 tube empty
//   remaining    cents still owed, saturated at 511
// Optional build macro CHANGE_AUDIT_EN adds audit_clr (input) and audit_total
// (output), a wrapping running total of cents dispensed.
module change_dispenser #(
   parameter int CNT_W   = 5,
   parameter int PULSE_W = 4,
   parameter int GAP_W   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] quart,
   input  logic [CNT_W-1:0] dim,
   input  logic [CNT_W-1:0] nick,
   input  logic             coin_ack,
   input  logic [2:0]       tube_empty,
   input  logic             fault_clr,
`ifdef CHANGE_AUDIT_EN
   input  logic             audit_clr,
   output logic [15:0]      audit_total,
`endif
   output logic             eject_q,
   output logic             eject_d,
   output logic             eject_n,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [8:0]       remaining
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SELECT   = 3'd1;
   localparam logic [2:0] EJECT    = 3'd2;
   localparam logic [2:0] WAIT_ACK = 3'd3;
   localparam logic [2:0] GAP      = 3'd4;
   localparam logic [2:0] DONE     = 3'd5;
   localparam logic [2:0] FAULT    = 3'd6;
   logic [2:0]       state;
   logic [2:0]       sel;
   logic [2:0]       pick;
   logic [CNT_W-1:0] q_left;
   logic [CNT_W-1:0] d_left;
   logic [CNT_W-1:0] n_left;
   logic [3:0]       pcnt;
   logic [7:0]       tcnt;
   logic             acked;
   logic             ack_take;
   logic             pulse_end;
   logic             timed_out;
   logic [2:0]       after_ack;
   logic [15:0]      sum;
   // sel/pick are one-hot {quarter, dime, nickel}; quarters have priority
   assign pick      = |q_left ? 3'b100 : |d_left ? 3'b010 : |n_left ? 3'b001 : 3'b000;
   // one decrement per eject: the first ack cycle is taken, later ones ignored
   assign ack_take  = (state == EJECT || state == WAIT_ACK) && coin_ack && !acked;
   assign pulse_end = pcnt == 4'(PULSE_W - 1);
   // tcnt is 0 in the first eject cycle, so the fault lands TIMEOUT cycles after eject start
   assign timed_out = tcnt >= 8'(TIMEOUT - 1);
   assign after_ack = GAP_W == 0 ? SELECT : GAP;
   assign sum       = 16'(q_left) * 16'd25 + 16'(d_left) * 16'd10 + 16'(n_left) * 16'd5;
   assign remaining = sum > 16'd511 ? 9'd511 : sum[8:0];
   assign eject_q   = state == EJECT && sel[2];
   assign eject_d   = state == EJECT && sel[1];
   assign eject_n   = state == EJECT && sel[0];
   assign busy      = state == SELECT || state == EJECT || state == WAIT_ACK || state == GAP;
   assign done      = state == DONE;
   assign fault     = state == FAULT;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         sel        <= 3'b000;
         q_left     <= '0;
         d_left     <= '0;
         n_left     <= '0;
         pcnt       <= 4'd0;
         tcnt       <= 8'd0;
         acked      <= 1'b0;
         fault_code <= 2'd0;
      end else begin
         case (state)
            IDLE: if (load) begin
               q_left <= quart;
               d_left <= dim;
               n_left <= nick;
               state  <= SELECT;
            end
            SELECT: begin
               pcnt  <= 4'd0;
               tcnt  <= 8'd0;
               acked <= 1'b0;
               sel   <= pick;
               if (pick == 3'b000) state <= DONE;
               else if (|(pick & tube_empty)) begin
                  state      <= FAULT;
                  fault_code <= 2'd2;
               end else state <= EJECT;
            end
            EJECT: begin
               pcnt <= pulse_end ? 4'd0 : pcnt + 4'd1;
               tcnt <= tcnt + 8'd1;
               // the pulse always runs to full length, even if the coin is already seen
               if (pulse_end) begin
                  if (acked || coin_ack) state <= after_ack;
                  else if (timed_out) begin
                     state      <= FAULT;
                     fault_code <= 2'd1;
                  end else state <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               tcnt <= tcnt + 8'd1;
               if (coin_ack) state <= after_ack;
               else if (timed_out) begin
                  state      <= FAULT;
                  fault_code <= 2'd1;
               end
            end
            GAP: begin
               pcnt <= pcnt + 4'd1;
               if (pcnt == 4'(GAP_W - 1)) state <= SELECT;
            end
            DONE: state <= IDLE;
            FAULT: if (fault_clr) begin
               state      <= IDLE;
               fault_code <= 2'd0;
               q_left     <= '0;
               d_left     <= '0;
               n_left     <= '0;
            end
            default: state <= IDLE;
         endcase
         if (ack_take) begin
            acked <= 1'b1;
            if (sel[2]) q_left <= q_left - CNT_W'(1);
            else if (sel[1]) d_left <= d_left - CNT_W'(1);
            else n_left <= n_left - CNT_W'(1);
         end
      end
   end
`ifdef CHANGE_AUDIT_EN
   logic [15:0] coin_val;
   assign coin_val = sel[2] ? 16'd25 : sel[1] ? 16'd10 : 16'd5;
   // clear takes effect first so a coin acknowledged in the same cycle still counts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) audit_total <= 16'd0;
      else audit_total <= (audit_clr ? 16'd0 : audit_total) + (ack_take ? coin_val : 16'd0);
   end
`endif
endmodule
